// File: rtl/mask_encoder.sv
// mask_encoder: compresses a dense element stream into windows of
// BITMASK_LENGTH elements. Each closed window is sent as one mask beat
// (bit i set when element i is nonzero) followed by the nonzero elements
// in ascending position order.
// Optional feature macro: MASK_ENCODER_DROP_EMPTY_EN -- when defined, an
// all-zero window that is not closed by din_last produces no beats at all.
module mask_encoder #(
    parameter int BITMASK_LENGTH = 4,
    parameter int ELEMENT_WIDTH  = 8,
    parameter int INDEX_BITWIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ELEMENT_WIDTH-1:0] din,
    input  logic                     din_valid,
    input  logic                     din_last,
    output logic                     din_ready,
    output logic [ELEMENT_WIDTH-1:0] dout_data,
    output logic                     dout_is_mask,
    output logic                     dout_last,
    output logic                     dout_valid,
    input  logic                     dout_ready
);

    typedef enum logic [1:0] {COLLECT, EMIT_MASK, EMIT_VALUES} state_t;

    localparam logic [INDEX_BITWIDTH-1:0] LAST_POS = INDEX_BITWIDTH'(BITMASK_LENGTH - 1);

    state_t                    state;
    logic [INDEX_BITWIDTH-1:0] pos;
    logic [BITMASK_LENGTH-1:0] mask;
    logic [BITMASK_LENGTH-1:0] remaining;   // set bits whose values are still to be emitted
    logic                      block_last;  // current window was closed by din_last
    logic [ELEMENT_WIDTH-1:0]  data_mem [BITMASK_LENGTH];

    logic                      accept_in;
    logic                      window_close;
    logic                      drop_window;
    logic [BITMASK_LENGTH-1:0] mask_next;
    logic [BITMASK_LENGTH-1:0] next_src;
    logic [INDEX_BITWIDTH-1:0] next_idx;
    logic [BITMASK_LENGTH-1:0] next_rem;
    logic [ELEMENT_WIDTH-1:0]  next_elem;

    // Index of the lowest set bit; zero when no bit is set.
    function automatic logic [INDEX_BITWIDTH-1:0] lowest_set(input logic [BITMASK_LENGTH-1:0] m);
        lowest_set = '0;
        for (int i = BITMASK_LENGTH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = INDEX_BITWIDTH'(i);
        end
    endfunction

    // Input is only taken while collecting; held low during the reset cycle.
    assign din_ready    = (state == COLLECT) && !reset;
    assign accept_in    = din_valid && din_ready;
    assign mask_next    = mask | (BITMASK_LENGTH'(din != '0) << pos);
    // Last position and din_last together still close just one window.
    assign window_close = (pos == LAST_POS) || din_last;

`ifdef MASK_ENCODER_DROP_EMPTY_EN
    assign drop_window  = (mask_next == '0) && !din_last;
`else
    assign drop_window  = 1'b0;
`endif

    // The next value to emit comes from the full mask when leaving the mask
    // beat, otherwise from the bits not yet emitted.
    assign next_src = (state == EMIT_MASK) ? mask : remaining;
    assign next_idx = lowest_set(next_src);
    assign next_rem = next_src & ~(BITMASK_LENGTH'(1) << next_idx);

    // Read mux for the stored element selected by next_idx.
    always_comb begin
        next_elem = '0;
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            if (next_idx == INDEX_BITWIDTH'(i)) next_elem = data_mem[i];
        end
    end

    // Element storage: written at the current position on every accepted input.
    always_ff @(posedge clock) begin
        if (accept_in) begin
            for (int i = 0; i < BITMASK_LENGTH; i++) begin
                if (pos == INDEX_BITWIDTH'(i)) data_mem[i] <= din;
            end
        end
    end

    // Window FSM with registered output beat; a beat only changes on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= COLLECT;
            pos          <= '0;
            mask         <= '0;
            remaining    <= '0;
            block_last   <= 1'b0;
            dout_valid   <= 1'b0;
            dout_is_mask <= 1'b0;
            dout_last    <= 1'b0;
            dout_data    <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept_in) begin
                        if (!window_close) begin
                            mask <= mask_next;
                            pos  <= pos + INDEX_BITWIDTH'(1);
                        end else if (drop_window) begin
                            mask <= '0;
                            pos  <= '0;
                        end else begin
                            state        <= EMIT_MASK;
                            mask         <= mask_next;
                            pos          <= '0;
                            block_last   <= din_last;
                            dout_valid   <= 1'b1;
                            dout_is_mask <= 1'b1;
                            dout_data    <= ELEMENT_WIDTH'(mask_next);
                            dout_last    <= din_last && (mask_next == '0);
                        end
                    end
                end
                EMIT_MASK, EMIT_VALUES: begin
                    if (dout_ready) begin
                        if (next_src == '0) begin
                            state        <= COLLECT;
                            mask         <= '0;
                            remaining    <= '0;
                            block_last   <= 1'b0;
                            dout_valid   <= 1'b0;
                            dout_is_mask <= 1'b0;
                            dout_last    <= 1'b0;
                        end else begin
                            state        <= EMIT_VALUES;
                            remaining    <= next_rem;
                            dout_is_mask <= 1'b0;
                            dout_data    <= next_elem;
                            dout_last    <= block_last && (next_rem == '0);
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_encoder.sv
// Testbench for mask_encoder: directed windows with hand-computed beats,
// stall/reset cases, then a random run rebuilt by a scoreboard.
module tb_mask_encoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_last;
    logic       din_ready;
    logic [7:0] dout_data;
    logic       dout_is_mask;
    logic       dout_last;
    logic       dout_valid;
    logic       dout_ready;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // scoreboard state for the random run
    logic [31:0] exp_q[$];
    logic [31:0] cur_group;
    int          group_fill;
    logic [3:0]  pend;
    logic [31:0] win;

    mask_encoder dut (
        .clock        (clock),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .din_last     (din_last),
        .din_ready    (din_ready),
        .dout_data    (dout_data),
        .dout_is_mask (dout_is_mask),
        .dout_last    (dout_last),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        din       = d;
        din_valid = 1'b1;
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic is_mask, input logic [7:0] data, input logic last);
        int n = 0;
        while (!dout_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"},   32'(dout_valid),   32'd1);
        check({tag, "_is_mask"}, 32'(dout_is_mask), 32'(is_mask));
        check({tag, "_data"},    32'(dout_data),    32'(data));
        check({tag, "_last"},    32'(dout_last),    32'(last));
        tick();
    endtask

    task automatic finish_window();
        check("rnd_window_available", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rnd_window", win, exp_q.pop_front());
    endtask

    task automatic take_beat();
        int k;
        if (dout_is_mask) begin
            check("rnd_mask_when_idle", 32'(pend), 32'd0);
            win  = '0;
            pend = dout_data[3:0];
            if (pend == 4'h0) finish_window();
        end else begin
            check("rnd_value_expected", 32'(pend != 4'h0), 32'd1);
            if (pend != 4'h0) begin
                k = 0;
                while (!pend[k]) k++;
                win[k*8 +: 8] = dout_data;
                pend[k] = 1'b0;
                if (pend == 4'h0) finish_window();
            end
        end
    endtask

    task automatic note_input(input logic [7:0] d);
        cur_group[group_fill*8 +: 8] = d;
        group_fill++;
        if (group_fill == 4) begin
`ifdef MASK_ENCODER_DROP_EMPTY_EN
            if (cur_group != '0) exp_q.push_back(cur_group);
`else
            exp_q.push_back(cur_group);
`endif
            group_fill = 0;
            cur_group  = '0;
        end
    endtask

    initial begin
        int sent;
        int cycles;
        logic       held;
        logic [7:0] held_data;
        logic       held_mask;
        logic       held_last;

        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b1;
        tick();
        tick();

        // reset state
        check("rst_dout_valid",   32'(dout_valid),   32'd0);
        check("rst_din_ready",    32'(din_ready),    32'd0);
        check("rst_dout_data",    32'(dout_data),    32'd0);
        check("rst_dout_is_mask", 32'(dout_is_mask), 32'd0);
        check("rst_dout_last",    32'(dout_last),    32'd0);
        reset = 1'b0;
        #1;
        check("rst_release_din_ready", 32'(din_ready), 32'd1);

        // 05,00,00,07 without last
        push(8'h05, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        push(8'h07, 1'b0);
        check("w1_mask_latency", 32'(dout_valid), 32'd1);
        check("w1_din_ready_low", 32'(din_ready), 32'd0);
        expect_beat("w1_mask", 1'b1, 8'h09, 1'b0);
        expect_beat("w1_v05",  1'b0, 8'h05, 1'b0);
        expect_beat("w1_v07",  1'b0, 8'h07, 1'b0);
        check("w1_din_ready_back", 32'(din_ready), 32'd1);
        check("w1_idle",           32'(dout_valid), 32'd0);

        // 00,03 with last on 03, then next window starts at position 0
        push(8'h00, 1'b0);
        push(8'h03, 1'b1);
        expect_beat("w2_mask", 1'b1, 8'h02, 1'b0);
        expect_beat("w2_v03",  1'b0, 8'h03, 1'b1);
        push(8'h08, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        expect_beat("w3_mask", 1'b1, 8'h01, 1'b0);
        expect_beat("w3_v08",  1'b0, 8'h08, 1'b0);

        // all-zero window without last
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
`ifdef MASK_ENCODER_DROP_EMPTY_EN
        check("w4_dropped_valid",    32'(dout_valid), 32'd0);
        check("w4_dropped_din_ready", 32'(din_ready), 32'd1);
`else
        expect_beat("w4_mask", 1'b1, 8'h00, 1'b0);
        check("w4_din_ready_back", 32'(din_ready), 32'd1);
`endif

        // all-zero window closed by last keeps its mask beat
        push(8'h00, 1'b0);
        push(8'h00, 1'b1);
        expect_beat("w5_mask", 1'b1, 8'h00, 1'b1);

        // last on the final position closes exactly one window
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b0);
        push(8'h04, 1'b1);
        expect_beat("w6_mask", 1'b1, 8'h0F, 1'b0);
        expect_beat("w6_v01",  1'b0, 8'h01, 1'b0);
        expect_beat("w6_v02",  1'b0, 8'h02, 1'b0);
        expect_beat("w6_v03",  1'b0, 8'h03, 1'b0);
        expect_beat("w6_v04",  1'b0, 8'h04, 1'b1);
        tick();
        check("w6_single_window", 32'(dout_valid), 32'd0);
        check("w6_din_ready",     32'(din_ready),  32'd1);

        // downstream stall for 5 cycles with input attempts during emission
        dout_ready = 1'b0;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        din       = 8'h55;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("w7_stall_valid", 32'(dout_valid),   32'd1);
            check("w7_stall_data",  32'(dout_data),    32'h0F);
            check("w7_stall_kind",  32'(dout_is_mask), 32'd1);
            check("w7_stall_noin",  32'(din_ready),    32'd0);
            tick();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        expect_beat("w7_mask", 1'b1, 8'h0F, 1'b0);
        expect_beat("w7_v11",  1'b0, 8'h11, 1'b0);
        expect_beat("w7_v22",  1'b0, 8'h22, 1'b0);
        expect_beat("w7_v33",  1'b0, 8'h33, 1'b0);
        check("w7_noin_before_44", 32'(din_ready), 32'd0);
        expect_beat("w7_v44",  1'b0, 8'h44, 1'b0);
        tick();
        tick();
        check("w7_no_stray_input", 32'(dout_valid), 32'd0);

        // reset while the second value is on the output
        push(8'hAA, 1'b0);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b0);
        push(8'hDD, 1'b0);
        expect_beat("w8_mask", 1'b1, 8'h0F, 1'b0);
        expect_beat("w8_vAA",  1'b0, 8'hAA, 1'b0);
        check("w8_second_value", 32'(dout_data), 32'hBB);
        reset = 1'b1;
        tick();
        check("w8_rst_valid",     32'(dout_valid), 32'd0);
        check("w8_rst_din_ready", 32'(din_ready),  32'd0);
        check("w8_rst_data",      32'(dout_data),  32'd0);
        reset = 1'b0;
        #1;
        check("w8_ready_after_rst", 32'(din_ready), 32'd1);
        push(8'h00, 1'b0);
        push(8'h09, 1'b0);
        push(8'h00, 1'b0);
        push(8'h00, 1'b0);
        expect_beat("w9_mask", 1'b1, 8'h02, 1'b0);
        expect_beat("w9_v09",  1'b0, 8'h09, 1'b0);

        // random stream rebuilt from mask and value beats
        cur_group  = '0;
        group_fill = 0;
        pend       = '0;
        win        = '0;
        sent       = 0;
        cycles     = 0;
        held       = 1'b0;
        held_data  = '0;
        held_mask  = 1'b0;
        held_last  = 1'b0;
        while (sent < 10000 && cycles < 80000) begin
            if (held) begin
                check("rnd_hold_valid", 32'(dout_valid), 32'd1);
                check("rnd_hold_beat", {22'd0, dout_last, dout_is_mask, dout_data},
                      {22'd0, held_last, held_mask, held_data});
            end
            din_valid  = ($urandom_range(0, 3) != 0);
            din        = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 255));
            din_last   = 1'b0;
            dout_ready = ($urandom_range(0, 1) != 0);
            if (din_valid && din_ready) begin
                note_input(din);
                sent++;
            end
            if (dout_valid && dout_ready) take_beat();
            held      = dout_valid && !dout_ready;
            held_data = dout_data;
            held_mask = dout_is_mask;
            held_last = dout_last;
            tick();
            cycles++;
        end
        check("rnd_all_sent", 32'(sent), 32'd10000);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (dout_valid) take_beat();
            tick();
        end
        check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_no_pending",    32'(pend),         32'd0);
        check("rnd_idle_end",      32'(dout_valid),   32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
